// File: rtl/execute_stage.sv
// Execute stage: ID/EX register, operand forwarding, ALU, bne/jal resolution, EX/MEM register.
// Redirect (pc_src_o/pc_target_o) is combinational from the ID/EX contents.
module execute_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall_i,
   input  logic            flush_i,
   input  logic            d_valid_i,
   input  logic [XLEN-1:0] d_pc_i,
   input  logic [XLEN-1:0] d_rd1_i,
   input  logic [XLEN-1:0] d_rd2_i,
   input  logic [XLEN-1:0] d_imm_i,
   input  logic [4:0]      d_rs1_i,
   input  logic [4:0]      d_rs2_i,
   input  logic [4:0]      d_rd_i,
   input  logic [2:0]      d_alu_control_i,
   input  logic            d_alu_src_i,
   input  logic            d_reg_write_i,
   input  logic            d_mem_write_i,
   input  logic            d_branch_i,
   input  logic            d_jump_i,
   input  logic [1:0]      d_result_src_i,
   input  logic [XLEN-1:0] wb_result_i,
   input  logic [4:0]      wb_rd_i,
   input  logic            wb_reg_write_i,
   output logic            pc_src_o,
   output logic [XLEN-1:0] pc_target_o,
   output logic [4:0]      ex_rd_o,
   output logic [1:0]      ex_result_src_o,
   output logic            m_valid_o,
   output logic            m_reg_write_o,
   output logic            m_mem_write_o,
   output logic [XLEN-1:0] m_alu_result_o,
   output logic [XLEN-1:0] m_write_data_o,
   output logic [4:0]      m_rd_o,
   output logic [1:0]      m_result_src_o
);

   localparam int SHW = $clog2(XLEN);

   typedef enum logic [2:0] {
      ALU_ADD  = 3'b000,
      ALU_SUB  = 3'b001,
      ALU_AND  = 3'b010,
      ALU_OR   = 3'b011,
      ALU_XOR  = 3'b100,
      ALU_LINK = 3'b101,
      ALU_SLL  = 3'b110,
      ALU_SRL  = 3'b111
   } alu_op_e;

   // ID/EX register
   logic            ex_valid_reg;
   logic [XLEN-1:0] ex_pc_reg;
   logic [XLEN-1:0] ex_rd1_reg;
   logic [XLEN-1:0] ex_rd2_reg;
   logic [XLEN-1:0] ex_imm_reg;
   logic [4:0]      ex_rs1_reg;
   logic [4:0]      ex_rs2_reg;
   logic [4:0]      ex_rd_reg;
   logic [2:0]      ex_alu_control_reg;
   logic            ex_alu_src_reg;
   logic            ex_reg_write_reg;
   logic            ex_mem_write_reg;
   logic            ex_branch_reg;
   logic            ex_jump_reg;
   logic [1:0]      ex_result_src_reg;

   // EX/MEM register
   logic            m_valid_reg;
   logic            m_reg_write_reg;
   logic            m_mem_write_reg;
   logic [XLEN-1:0] m_alu_result_reg;
   logic [XLEN-1:0] m_write_data_reg;
   logic [4:0]      m_rd_reg;
   logic [1:0]      m_result_src_reg;

   logic [XLEN-1:0] src_a;
   logic [XLEN-1:0] fwd_b;
   logic [XLEN-1:0] src_b;
   logic [XLEN-1:0] alu_result;
   logic            alu_zero;
   logic [SHW-1:0]  shamt;

   always_ff @(posedge clk) begin
      if (!rst_n || flush_i) begin
         ex_valid_reg       <= 1'b0;
         ex_pc_reg          <= '0;
         ex_rd1_reg         <= '0;
         ex_rd2_reg         <= '0;
         ex_imm_reg         <= '0;
         ex_rs1_reg         <= '0;
         ex_rs2_reg         <= '0;
         ex_rd_reg          <= '0;
         ex_alu_control_reg <= '0;
         ex_alu_src_reg     <= 1'b0;
         ex_reg_write_reg   <= 1'b0;
         ex_mem_write_reg   <= 1'b0;
         ex_branch_reg      <= 1'b0;
         ex_jump_reg        <= 1'b0;
         ex_result_src_reg  <= '0;
      end else if (!stall_i) begin
         ex_valid_reg       <= d_valid_i;
         ex_pc_reg          <= d_pc_i;
         ex_rd1_reg         <= d_rd1_i;
         ex_rd2_reg         <= d_rd2_i;
         ex_imm_reg         <= d_imm_i;
         ex_rs1_reg         <= d_rs1_i;
         ex_rs2_reg         <= d_rs2_i;
         ex_rd_reg          <= d_rd_i;
         ex_alu_control_reg <= d_alu_control_i;
         ex_alu_src_reg     <= d_alu_src_i;
         ex_reg_write_reg   <= d_reg_write_i;
         ex_mem_write_reg   <= d_mem_write_i;
         ex_branch_reg      <= d_branch_i;
         ex_jump_reg        <= d_jump_i;
         ex_result_src_reg  <= d_result_src_i;
      end
   end

   // Per-operand forwarding: EX/MEM beats MEM/WB, x0 is never forwarded.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
         logic [4:0]      rs;
         logic [XLEN-1:0] stale;
         logic [XLEN-1:0] val;

         assign rs    = (gi == 0) ? ex_rs1_reg : ex_rs2_reg;
         assign stale = (gi == 0) ? ex_rd1_reg : ex_rd2_reg;

         always_comb begin
            val = stale;
            if (m_reg_write_reg && (m_rd_reg != 5'd0) && (m_rd_reg == rs))
               val = m_alu_result_reg;
            else if (wb_reg_write_i && (wb_rd_i != 5'd0) && (wb_rd_i == rs))
               val = wb_result_i;
         end
      end
   endgenerate

   assign src_a = g_fwd[0].val;
   assign fwd_b = g_fwd[1].val;
   assign src_b = ex_alu_src_reg ? ex_imm_reg : fwd_b;
   assign shamt = src_b[SHW-1:0];

   always_comb begin
      alu_result = '0;
      case (alu_op_e'(ex_alu_control_reg))
         ALU_ADD:  alu_result = src_a + src_b;
         ALU_SUB:  alu_result = src_a - src_b;
         ALU_AND:  alu_result = src_a & src_b;
         ALU_OR:   alu_result = src_a | src_b;
         ALU_XOR:  alu_result = src_a ^ src_b;
         ALU_LINK: alu_result = ex_pc_reg + XLEN'(4);
         ALU_SLL:  alu_result = src_a << shamt;
         ALU_SRL:  alu_result = src_a >> shamt;
         default:  alu_result = '0;
      endcase
   end

   assign alu_zero = (alu_result == '0);

   // bne is decoded as sub, so "not equal" is a nonzero difference.
   assign pc_src_o    = ex_valid_reg && (ex_jump_reg || (ex_branch_reg && !alu_zero));
   assign pc_target_o = ex_pc_reg + ex_imm_reg;

   always_ff @(posedge clk) begin
      if (!rst_n || stall_i || !ex_valid_reg) begin
         m_valid_reg      <= 1'b0;
         m_reg_write_reg  <= 1'b0;
         m_mem_write_reg  <= 1'b0;
         m_alu_result_reg <= '0;
         m_write_data_reg <= '0;
         m_rd_reg         <= '0;
         m_result_src_reg <= '0;
      end else begin
         m_valid_reg      <= 1'b1;
         m_reg_write_reg  <= ex_reg_write_reg;
         m_mem_write_reg  <= ex_mem_write_reg;
         m_alu_result_reg <= alu_result;
         m_write_data_reg <= fwd_b;
         m_rd_reg         <= ex_rd_reg;
         m_result_src_reg <= ex_result_src_reg;
      end
   end

   assign ex_rd_o         = ex_rd_reg;
   assign ex_result_src_o = ex_result_src_reg;
   assign m_valid_o       = m_valid_reg;
   assign m_reg_write_o   = m_reg_write_reg;
   assign m_mem_write_o   = m_mem_write_reg;
   assign m_alu_result_o  = m_alu_result_reg;
   assign m_write_data_o  = m_write_data_reg;
   assign m_rd_o          = m_rd_reg;
   assign m_result_src_o  = m_result_src_reg;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed scenarios plus randomized traffic against a
// cycle-level reference model built from the forwarding/ALU/branch rules.
module tb_execute_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall_i, flush_i, d_valid_i;
   logic [31:0] d_pc_i, d_rd1_i, d_rd2_i, d_imm_i;
   logic [4:0]  d_rs1_i, d_rs2_i, d_rd_i;
   logic [2:0]  d_alu_control_i;
   logic        d_alu_src_i, d_reg_write_i, d_mem_write_i, d_branch_i, d_jump_i;
   logic [1:0]  d_result_src_i;
   logic [31:0] wb_result_i;
   logic [4:0]  wb_rd_i;
   logic        wb_reg_write_i;
   logic        pc_src_o;
   logic [31:0] pc_target_o;
   logic [4:0]  ex_rd_o;
   logic [1:0]  ex_result_src_o;
   logic        m_valid_o, m_reg_write_o, m_mem_write_o;
   logic [31:0] m_alu_result_o, m_write_data_o;
   logic [4:0]  m_rd_o;
   logic [1:0]  m_result_src_o;

   execute_stage #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
      .d_valid_i(d_valid_i), .d_pc_i(d_pc_i), .d_rd1_i(d_rd1_i), .d_rd2_i(d_rd2_i),
      .d_imm_i(d_imm_i), .d_rs1_i(d_rs1_i), .d_rs2_i(d_rs2_i), .d_rd_i(d_rd_i),
      .d_alu_control_i(d_alu_control_i), .d_alu_src_i(d_alu_src_i),
      .d_reg_write_i(d_reg_write_i), .d_mem_write_i(d_mem_write_i),
      .d_branch_i(d_branch_i), .d_jump_i(d_jump_i), .d_result_src_i(d_result_src_i),
      .wb_result_i(wb_result_i), .wb_rd_i(wb_rd_i), .wb_reg_write_i(wb_reg_write_i),
      .pc_src_o(pc_src_o), .pc_target_o(pc_target_o), .ex_rd_o(ex_rd_o),
      .ex_result_src_o(ex_result_src_o), .m_valid_o(m_valid_o),
      .m_reg_write_o(m_reg_write_o), .m_mem_write_o(m_mem_write_o),
      .m_alu_result_o(m_alu_result_o), .m_write_data_o(m_write_data_o),
      .m_rd_o(m_rd_o), .m_result_src_o(m_result_src_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      bit        valid;
      bit [31:0] pc, rd1, rd2, imm;
      bit [4:0]  rs1, rs2, rd;
      bit [2:0]  op;
      bit        src, rw, mw, br, jp;
      bit [1:0]  rsrc;
   } instr_t;

   typedef struct packed {
      bit        valid, rw, mw;
      bit [31:0] alu, wdata;
      bit [4:0]  rd;
      bit [1:0]  rsrc;
   } mres_t;

   instr_t mdl_id;
   mres_t  mdl_m;
   int     total = 0;
   int     bad = 0;
   int     cyc = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic bit [31:0] alu_model(input bit [2:0] op, input bit [31:0] a, input bit [31:0] b,
                                           input bit [31:0] pc);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return pc + 32'd4;
         3'd6:    return a << b[4:0];
         default: return a >> b[4:0];
      endcase
   endfunction

   // Value the instruction in EX should see for register rs.
   function automatic bit [31:0] operand(input bit [4:0] rs, input bit [31:0] stale);
      if (rs != 0 && mdl_m.rw && mdl_m.rd == rs) return mdl_m.alu;
      if (rs != 0 && wb_reg_write_i && wb_rd_i == rs) return wb_result_i;
      return stale;
   endfunction

   function automatic bit [31:0] ex_result();
      bit [31:0] a, b;
      a = operand(mdl_id.rs1, mdl_id.rd1);
      b = operand(mdl_id.rs2, mdl_id.rd2);
      return alu_model(mdl_id.op, a, mdl_id.src ? mdl_id.imm : b, mdl_id.pc);
   endfunction

   // One clock: check the redirect, advance the model at the edge, check the registers.
   task automatic cycle();
      bit        exp_src;
      bit [31:0] res;
      mres_t     nm;
      #1;
      res = ex_result();
      exp_src = mdl_id.valid && (mdl_id.jp || (mdl_id.br && res != 0));
      check_val("pc_src", pc_src_o, exp_src);
      if (mdl_id.valid) check_val("pc_target", pc_target_o, mdl_id.pc + mdl_id.imm);
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
         mdl_id = '0;
         mdl_m  = '0;
      end else begin
         nm = '0;
         if (!stall_i && mdl_id.valid) begin
            nm.valid = 1;
            nm.rw    = mdl_id.rw;
            nm.mw    = mdl_id.mw;
            nm.alu   = res;
            nm.wdata = operand(mdl_id.rs2, mdl_id.rd2);
            nm.rd    = mdl_id.rd;
            nm.rsrc  = mdl_id.rsrc;
         end
         if (flush_i) mdl_id = '0;
         else if (!stall_i)
            mdl_id = '{d_valid_i, d_pc_i, d_rd1_i, d_rd2_i, d_imm_i, d_rs1_i, d_rs2_i, d_rd_i,
                       d_alu_control_i, d_alu_src_i, d_reg_write_i, d_mem_write_i,
                       d_branch_i, d_jump_i, d_result_src_i};
         mdl_m = nm;
      end
      #1;
      check_val("m_valid", m_valid_o, mdl_m.valid);
      check_val("m_reg_write", m_reg_write_o, mdl_m.rw);
      check_val("m_mem_write", m_mem_write_o, mdl_m.mw);
      check_val("ex_rd", ex_rd_o, mdl_id.rd);
      check_val("ex_result_src", ex_result_src_o, mdl_id.rsrc);
      if (mdl_m.valid) begin
         check_val("m_alu_result", m_alu_result_o, mdl_m.alu);
         check_val("m_write_data", m_write_data_o, mdl_m.wdata);
         check_val("m_rd", m_rd_o, mdl_m.rd);
         check_val("m_result_src", m_result_src_o, mdl_m.rsrc);
      end
      $display("cyc %0d rst_n=%0d stall=%0d flush=%0d m_valid=%0d m_rd=%0d m_alu=%h pc_src=%0d",
               cyc, rst_n, stall_i, flush_i, m_valid_o, m_rd_o, m_alu_result_o, pc_src_o);
   endtask

   task automatic clear_side();
      wb_reg_write_i = 0; wb_rd_i = 0; wb_result_i = 0;
      stall_i = 0; flush_i = 0;
   endtask

   task automatic drive(input bit [31:0] pc, input bit [31:0] rd1, input bit [31:0] rd2,
                        input bit [31:0] imm, input bit [4:0] rs1, input bit [4:0] rs2,
                        input bit [4:0] rd, input bit [2:0] op, input bit src, input bit rw,
                        input bit br, input bit jp);
      d_valid_i = 1; d_pc_i = pc; d_rd1_i = rd1; d_rd2_i = rd2; d_imm_i = imm;
      d_rs1_i = rs1; d_rs2_i = rs2; d_rd_i = rd; d_alu_control_i = op; d_alu_src_i = src;
      d_reg_write_i = rw; d_mem_write_i = 0; d_branch_i = br; d_jump_i = jp;
      d_result_src_i = 0;
      clear_side();
   endtask

   task automatic nop();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      d_valid_i = 0;
   endtask

   bit [31:0] sweep_exp [8];

   initial begin
      sweep_exp = '{32'hF0F0_0004, 32'hF0EF_FFFC, 32'h0, 32'hF0F0_0004,
                    32'hF0F0_0004, 32'h0000_0044, 32'h0F00_0000, 32'h0F0F_0000};
      mdl_id = '0;
      mdl_m  = '0;
      rst_n = 0;
      drive(32'h10, 0, 0, 7, 0, 0, 5, 3'd0, 1, 1, 0, 1);   // valid jal-ish during reset
      @(posedge clk);
      #1;
      cycle();
      cycle();
      check_val("rst_m_valid", m_valid_o, 0);
      check_val("rst_pc_src", pc_src_o, 0);

      // Release; addi x5,x0,7 captured at edge N, visible after N+1.
      rst_n = 1;
      drive(32'h10, 0, 0, 7, 0, 0, 5, 3'd0, 1, 1, 0, 0);
      cycle();
      check_val("lat_n_valid", m_valid_o, 0);
      drive(32'h14, 0, 0, 0, 5, 5, 6, 3'd0, 0, 1, 0, 0);  // add x6,x5,x5 stale 0
      cycle();
      check_val("lat_n1_valid", m_valid_o, 1);
      nop();
      cycle();
      check_val("fwd_exmem", m_alu_result_o, 14);

      // MEM/WB path with one nop between.
      drive(32'h20, 0, 0, 7, 0, 0, 5, 3'd0, 1, 1, 0, 0);
      cycle();
      nop();
      cycle();
      drive(32'h28, 0, 0, 0, 5, 5, 6, 3'd0, 0, 1, 0, 0);
      cycle();
      nop();
      wb_result_i = 7; wb_rd_i = 5; wb_reg_write_i = 1;
      cycle();
      check_val("fwd_wb", m_alu_result_o, 14);

      // Both paths match x5: EX/MEM wins.
      drive(32'h30, 0, 0, 7, 0, 0, 5, 3'd0, 1, 1, 0, 0);
      cycle();
      drive(32'h34, 0, 0, 0, 5, 5, 6, 3'd0, 0, 1, 0, 0);
      cycle();
      nop();
      wb_result_i = 99; wb_rd_i = 5; wb_reg_write_i = 1;
      cycle();
      check_val("fwd_prio", m_alu_result_o, 14);

      // Writes to x0 are never forwarded.
      drive(32'h40, 0, 0, 9, 0, 0, 0, 3'd0, 1, 1, 0, 0);
      cycle();
      drive(32'h44, 0, 0, 0, 0, 0, 6, 3'd0, 0, 1, 0, 0);
      cycle();
      nop();
      wb_result_i = 9; wb_rd_i = 0; wb_reg_write_i = 1;
      cycle();
      check_val("fwd_x0", m_alu_result_o, 0);

      // ALU sweep.
      for (int i = 0; i < 8; i++) begin
         drive(32'h40, 32'hF0F0_0000, 32'h4, 0, 1, 2, 7, 3'(i), 0, 0, 0, 0);
         cycle();
         nop();
         cycle();
         check_val($sformatf("alu_op%0d", i), m_alu_result_o, sweep_exp[i]);
      end
      drive(32'h40, 32'hFFFF_FFFF, 0, 1, 1, 0, 7, 3'd0, 1, 0, 0, 0);
      cycle();
      nop();
      cycle();
      check_val("alu_wrap", m_alu_result_o, 0);

      // bne / jal.
      drive(32'h100, 3, 3, 32'h20, 1, 2, 0, 3'd1, 0, 0, 1, 0);
      cycle();
      check_val("bne_eq", pc_src_o, 0);
      drive(32'h100, 3, 4, 32'h20, 1, 2, 0, 3'd1, 0, 0, 1, 0);
      cycle();
      check_val("bne_ne", pc_src_o, 1);
      check_val("bne_tgt", pc_target_o, 32'h120);
      drive(32'h200, 0, 0, 32'hFFFF_FFF8, 0, 0, 1, 3'd5, 0, 1, 0, 1);
      cycle();
      check_val("jal_src", pc_src_o, 1);
      check_val("jal_tgt", pc_target_o, 32'h1F8);
      nop();
      cycle();
      check_val("jal_link", m_alu_result_o, 32'h204);

      // Two-cycle stall mid-stream: no loss, no duplication.
      drive(32'h300, 0, 0, 10, 0, 0, 10, 3'd0, 1, 1, 0, 0);
      cycle();
      drive(32'h304, 0, 0, 11, 0, 0, 11, 3'd0, 1, 1, 0, 0);
      cycle();
      check_val("stl_i1", m_alu_result_o, 10);
      drive(32'h308, 0, 0, 12, 0, 0, 12, 3'd0, 1, 1, 0, 0);
      stall_i = 1;
      cycle();
      check_val("stl_bub1", m_reg_write_o, 0);
      check_val("stl_hold1", ex_rd_o, 11);
      cycle();
      check_val("stl_bub2", m_reg_write_o, 0);
      stall_i = 0;
      cycle();
      check_val("stl_i2", m_alu_result_o, 11);
      drive(32'h30C, 0, 0, 13, 0, 0, 13, 3'd0, 1, 1, 0, 0);
      cycle();
      check_val("stl_i3", m_alu_result_o, 12);
      nop();
      cycle();
      check_val("stl_i4", m_alu_result_o, 13);

      // stall + flush together: ID/EX becomes a bubble.
      drive(32'h200, 0, 0, 32'hFFFF_FFF8, 0, 0, 1, 3'd5, 0, 1, 0, 1);
      cycle();
      nop();
      stall_i = 1; flush_i = 1;
      cycle();
      check_val("sf_pc_src", pc_src_o, 0);
      check_val("sf_valid", m_valid_o, 0);
      clear_side();

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         rst_n           = ($urandom_range(0, 49) != 0);
         stall_i         = ($urandom_range(0, 4) == 0);
         flush_i         = ($urandom_range(0, 9) == 0);
         d_valid_i       = ($urandom_range(0, 5) != 0);
         d_pc_i          = $urandom & 32'hFFFF_FFFC;
         d_rd1_i         = $urandom;
         d_rd2_i         = ($urandom_range(0, 3) == 0) ? d_rd1_i : $urandom;
         d_imm_i         = $urandom;
         d_rs1_i         = 5'($urandom_range(0, 3));
         d_rs2_i         = 5'($urandom_range(0, 3));
         d_rd_i          = 5'($urandom_range(0, 3));
         d_alu_control_i = 3'($urandom_range(0, 7));
         d_alu_src_i     = 1'($urandom_range(0, 1));
         d_reg_write_i   = 1'($urandom_range(0, 1));
         d_mem_write_i   = 1'($urandom_range(0, 1));
         d_branch_i      = ($urandom_range(0, 4) == 0);
         d_jump_i        = ($urandom_range(0, 6) == 0);
         d_result_src_i  = 2'($urandom_range(0, 3));
         if (d_branch_i) begin
            d_alu_control_i = 3'd1; d_alu_src_i = 0; d_reg_write_i = 0; d_jump_i = 0;
         end else if (d_jump_i) begin
            d_alu_control_i = 3'd5; d_reg_write_i = 1;
         end
         if (d_mem_write_i) d_reg_write_i = 0;
         wb_reg_write_i  = 1'($urandom_range(0, 1));
         wb_rd_i         = 5'($urandom_range(0, 3));
         wb_result_i     = $urandom;
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Downstream consumer of the decode stage's 3-bit ALUControl and control bundle.
- Contains the ID/EX pipeline register, the operand forwarding muxes, the ALU, bne/jal branch resolution and the EX/MEM pipeline register.
- Produces the PC redirect that the fetch stage and the hazard unit consume.

Parameters:
- XLEN, 32, datapath width; shift amount is SrcB[$clog2(XLEN)-1:0].

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- stall_i  in  1  hold ID/EX and inject bubble into EX/MEM (load-use, from hazard unit)
- flush_i  in  1  load bubble into ID/EX
- d_valid_i  in  1  decode slot holds a real instruction
- d_pc_i  in  XLEN  instruction PC
- d_rd1_i, d_rd2_i  in  XLEN  register file read data
- d_imm_i  in  XLEN  sign-extended immediate
- d_rs1_i, d_rs2_i, d_rd_i  in  5  register indices
- d_alu_control_i  in  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 link, 110 sll, 111 srl
- d_alu_src_i  in  1  1 = SrcB is imm
- d_reg_write_i, d_mem_write_i, d_branch_i, d_jump_i  in  1  control
- d_result_src_i  in  2  writeback select, passed through
- wb_result_i  in  XLEN  MEM/WB writeback value
- wb_rd_i  in  5  MEM/WB destination
- wb_reg_write_i  in  1  MEM/WB write enable
- pc_src_o  out  1  redirect PC (combinational)
- pc_target_o  out  XLEN  redirect address (combinational)
- ex_rd_o  out  5  ID/EX rd, for hazard unit
- ex_result_src_o  out  2  ID/EX result_src, for hazard unit
- m_valid_o, m_reg_write_o, m_mem_write_o  out  1  EX/MEM registered
- m_alu_result_o  out  XLEN  EX/MEM ALU result
- m_write_data_o  out  XLEN  forwarded rs2 value (store data)
- m_rd_o  out  5  EX/MEM destination
- m_result_src_o  out  2  EX/MEM writeback select

Behaviour:
- Reset (rst_n=0 at edge): all ID/EX and EX/MEM fields cleared to 0. All m_* outputs 0, pc_src_o 0. Reset overrides stall/flush. Reset mid-operation discards in-flight instructions.
- ID/EX update per edge, in priority order:
  - flush_i: bubble (valid, reg_write, mem_write, branch, jump all 0; data don't-care, cleared to 0).
  - else stall_i: hold.
  - else capture d_*.
  - flush_i wins over stall_i.
- EX/MEM update per edge:
  - stall_i or ID/EX invalid: bubble (m_valid 0, m_reg_write 0, m_mem_write 0).
  - else capture the EX results.
- Latency: decode inputs captured at edge N; m_* valid after edge N+1.
- Forwarding, per operand rsX of the ID/EX instruction, in priority order:
  1. If m_reg_write_o && m_rd_o!=0 && m_rd_o==rsX: use m_alu_result_o.
  2. Else if wb_reg_write_i && wb_rd_i!=0 && wb_rd_i==rsX: use wb_result_i.
  3. Else use the ID/EX rd1/rd2.
  - x0 is never forwarded.
  - Load data is not forwarded from EX/MEM. The hazard unit must stall, using ex_result_src_o and ex_rd_o.
- SrcA = forwarded rs1. SrcB = alu_src ? imm : forwarded rs2. m_write_data = forwarded rs2.
- ALU, modulo 2^XLEN, no flags except zero:
  - add/sub wrap.
  - sll/srl are logical, using the low $clog2(XLEN) bits of SrcB.
  - link returns pc+4.
  - Undefined codes are impossible (3-bit fully mapped).
- Branch resolution, combinational from ID/EX:
  - pc_src_o = valid && (jump || (branch && alu_result!=0)), i.e. bne taken when sub result nonzero.
  - pc_target_o = pc + imm (wrap).
  - pc_src_o is independent of stall_i; the upstream unit must assert flush_i on the decode register and ID/EX for the next edge.
- Branches and stores: m_reg_write is taken from control (bne and sb have reg_write 0 from decode). No internal override beyond the bubble rule.

Test Plan:
- Reset: hold rst_n=0 two cycles with d_valid_i=1 -> all m_* 0, pc_src_o 0. Release -> first m_valid_o exactly 2 edges after capture.
- Back-to-back forward: addi x5,x0,7 then add x6,x5,x5 with stale d_rd1=d_rd2=0 -> m_alu_result=14 (EX/MEM path). Insert one nop between -> still 14 via wb_result_i=7. Both paths matching rd5 -> EX/MEM value wins. rd=x0 with result 9 -> not forwarded.
- ALU sweep: SrcA=0xF0F0_0000, SrcB=0x0000_0004 through codes 000..111 -> 0xF0F0_0004, 0xF0EF_FFFC, 0, 0xF0F0_0004, 0xF0F0_0004, pc+4, 0x0F00_0000, 0x0F0F_0000. Also 0xFFFF_FFFF+1 add -> 0.
- bne at pc=0x100, imm=0x20, rs1=3, rs2=3 -> pc_src_o 0. With rs2=4 -> pc_src_o 1, pc_target_o 0x120. jal at pc=0x200, imm=-8 -> pc_src_o 1, target 0x1F8, m_alu_result 0x204.
- stall_i for 2 cycles mid-stream -> ID/EX held, two EX/MEM bubbles (m_reg_write 0), no instruction lost or duplicated.
- stall_i and flush_i asserted together -> ID/EX becomes bubble, pc_src_o 0 next cycle.
